// File: rtl/seq_mag_comp_if.sv
// Operand/result bundle for seq_mag_comp: start/a/b in, busy/done/gt/lt/eq out.
// fsm_state mirrors the comparator's state register for observation.
interface seq_mag_comp_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [1:0]       fsm_state;

  modport master (output start, a, b, input busy, done, gt, lt, eq, fsm_state);
  modport slave  (input start, a, b, output busy, done, gt, lt, eq, fsm_state);
endinterface

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: DIGIT bits per clock, MSB slice first, early exit.
// Optional SEQ_MAG_COMP_SIGNED_EN treats operands as two's complement.
//
// Handshake: start is sampled on the rising edge and accepted only in IDLE or
// DONE (busy==0); busy is high for every RUN cycle; done is high for exactly
// the one DONE cycle, from which gt/lt/eq are valid and held until the next DONE.
module seq_mag_comp #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  seq_mag_comp_if.slave  bus
);
  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = $clog2(NSLICE) + 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             gt_q;
  logic             lt_q;
  logic             eq_q;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [DIGIT-1:0] top_a;
  logic [DIGIT-1:0] top_b;

`ifdef SEQ_MAG_COMP_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};
  assign cap_a = bus.a ^ SIGN_MASK;
  assign cap_b = bus.b ^ SIGN_MASK;
`else
  assign cap_a = bus.a;
  assign cap_b = bus.b;
`endif

  assign top_a = sh_a[WIDTH-1 -: DIGIT];
  assign top_b = sh_b[WIDTH-1 -: DIGIT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      gt_q  <= 1'b0;
      lt_q  <= 1'b0;
      eq_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            sh_a  <= cap_a;
            sh_b  <= cap_b;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (top_a > top_b) begin
            {gt_q, lt_q, eq_q} <= 3'b100;
            state              <= S_DONE;
          end else if (top_a < top_b) begin
            {gt_q, lt_q, eq_q} <= 3'b010;
            state              <= S_DONE;
          end else if (cnt == LAST_SLICE) begin
            {gt_q, lt_q, eq_q} <= 3'b001;
            state              <= S_DONE;
          end else begin
            // Equal slice so far: expose the next lower slice at the top.
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == S_RUN);
  assign bus.done      = (state == S_DONE);
  assign bus.gt        = gt_q;
  assign bus.lt        = lt_q;
  assign bus.eq        = eq_q;
  assign bus.fsm_state = state;
endmodule
